counter_checker: RTL and testbench

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_chk_pkg.sv | 17 +
 rtl/counter_ref_model.sv | 35 +++
 rtl/counter_checker.sv | 99 +++++++++
 tb/tb_counter_checker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/counter_chk_pkg.sv
// Shared types and constants for the counter checker.
//   chk_state_e    : checker FSM states
//   TYPE_*_BIT     : bit positions inside first_type
package counter_chk_pkg;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    CHECK  = 2'd1,
    FAIL   = 2'd2
  } chk_state_e;

  localparam int TYPE_CNT_BIT  = 0;  // count_out disagreed
  localparam int TYPE_MAX_BIT  = 1;  // max_count disagreed
  localparam int TYPE_ZERO_BIT = 2;  // zero disagreed
  localparam int TYPE_W        = 3;

endpackage

// File: rtl/counter_ref_model.sv
// Reference model of the monitored up/down counter.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rst_n, load_n,
//   up_down, ce,
//   data_load             : observed counter controls
//   ref_cnt               : model value (state before the current edge)
//   max_exp, zero_exp     : expected flags derived from ref_cnt
module counter_ref_model #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             up_down,
  input  logic             ce,
  input  logic [WIDTH-1:0] data_load,
  output logic [WIDTH-1:0] ref_cnt,
  output logic             max_exp,
  output logic             zero_exp
);

  // Priority: counter reset, then load, then count; arithmetic wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)          ref_cnt <= '0;
    else if (!rst_n)  ref_cnt <= '0;
    else if (!load_n) ref_cnt <= data_load;
    else if (ce)      ref_cnt <= up_down ? ref_cnt + WIDTH'(1) : ref_cnt - WIDTH'(1);
  end

  assign max_exp  = &ref_cnt;
  assign zero_exp = ~|ref_cnt;

endmodule

// File: rtl/counter_checker.sv
// Monitor that compares an observed counter against a reference model.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : soft clear back to UNSYNC, statistics zeroed
//   rst_n, load_n, up_down, ce, data_load : observed counter controls
//   count_out, max_count, zero            : observed counter outputs
//   synced          : checker is locked (CHECK or FAIL)
//   err_flag        : sticky, a mismatch has been seen
//   chk_count       : compared cycles, saturating
//   err_count       : mismatching cycles, saturating
//   first_exp/got   : expected/observed count at first mismatch
//   first_type      : which of count/max/zero disagreed at first mismatch
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              rst_n,
  input  logic              load_n,
  input  logic              up_down,
  input  logic              ce,
  input  logic [WIDTH-1:0]  data_load,
  input  logic [WIDTH-1:0]  count_out,
  input  logic              max_count,
  input  logic              zero,
  output logic              synced,
  output logic              err_flag,
  output logic [CNT_W-1:0]  chk_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [WIDTH-1:0]  first_exp,
  output logic [WIDTH-1:0]  first_got,
  output logic [TYPE_W-1:0] first_type
);

  chk_state_e        state;
  logic [WIDTH-1:0]  ref_cnt;
  logic              max_exp, zero_exp;
  logic [TYPE_W-1:0] mis_type;
  logic              mismatch;

  // The model keeps tracking the observed controls in every state, so a
  // counter reset seen while locked only re-aligns the model.
  counter_ref_model #(.WIDTH(WIDTH)) u_ref (
    .clk       (clk),
    .rst       (rst),
    .rst_n     (rst_n),
    .load_n    (load_n),
    .up_down   (up_down),
    .ce        (ce),
    .data_load (data_load),
    .ref_cnt   (ref_cnt),
    .max_exp   (max_exp),
    .zero_exp  (zero_exp)
  );

  // Compare against the pre-update model value.
  always_comb begin
    mis_type                = '0;
    mis_type[TYPE_CNT_BIT]  = (count_out != ref_cnt);
    mis_type[TYPE_MAX_BIT]  = (max_count != max_exp);
    mis_type[TYPE_ZERO_BIT] = (zero      != zero_exp);
  end
  assign mismatch = |mis_type;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= UNSYNC;
      chk_count  <= '0;
      err_count  <= '0;
      first_exp  <= '0;
      first_got  <= '0;
      first_type <= '0;
    end else begin
      case (state)
        // The locking edge itself is not compared.
        UNSYNC: if (!rst_n) state <= CHECK;
        CHECK, FAIL: begin
          if (~&chk_count) chk_count <= chk_count + CNT_W'(1);
          if (mismatch && ~&err_count) err_count <= err_count + CNT_W'(1);
          if (state == CHECK && mismatch) begin
            state      <= FAIL;
            first_exp  <= ref_cnt;
            first_got  <= count_out;
            first_type <= mis_type;
          end
        end
        default: state <= UNSYNC;
      endcase
    end
  end

  assign synced   = (state != UNSYNC);
  assign err_flag = (state == FAIL);

endmodule

// File: tb/tb_counter_checker.sv
`timescale 1ns/1ps
module tb_counter_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int VMAX  = (1 << WIDTH) - 1;

  logic clk = 0, rst = 1, clr = 0;
  logic rst_n = 1, load_n = 1, up_down = 1, ce = 0;
  logic [WIDTH-1:0] data_load = '0, count_out = '0;
  logic max_count = 0, zero = 1;
  logic synced, err_flag;
  logic [CNT_W-1:0] chk_count, err_count;
  logic [WIDTH-1:0] first_exp, first_got;
  logic [2:0] first_type;

  int n_cmp = 0, n_bad = 0;
  // Behavioural model: counter value and checker bookkeeping as plain ints.
  int m = 0, st = 0, chk = 0, err = 0, fexp = 0, fgot = 0, ftyp = 0;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .rst_n(rst_n), .load_n(load_n),
    .up_down(up_down), .ce(ce), .data_load(data_load), .count_out(count_out),
    .max_count(max_count), .zero(zero), .synced(synced), .err_flag(err_flag),
    .chk_count(chk_count), .err_count(err_count), .first_exp(first_exp),
    .first_got(first_got), .first_type(first_type)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic ctl(input bit rn, input bit ln, input bit ud, input bit c, input int dl);
    rst_n = rn; load_n = ln; up_down = ud; ce = c; data_load = WIDTH'(dl);
  endtask

  // One clock: drive observed counter (correct unless faulted), advance model, check.
  task automatic step(input bit f_cnt = 0, input bit f_max = 0, input bit f_zero = 0);
    int cm, mm, zm;
    count_out = WIDTH'(m + (f_cnt ? 1 : 0));
    max_count = (m == VMAX) ^ f_max;
    zero      = (m == 0) ^ f_zero;
    cm = (int'(count_out) != m);
    mm = (max_count != (m == VMAX));
    zm = (zero != (m == 0));
    @(posedge clk);
    if (rst) begin
      st = 0; chk = 0; err = 0; fexp = 0; fgot = 0; ftyp = 0; m = 0;
    end else begin
      if (clr) begin
        st = 0; chk = 0; err = 0; fexp = 0; fgot = 0; ftyp = 0;
      end else if (st == 0) begin
        if (!rst_n) st = 1;
      end else begin
        if (chk < CMAX) chk++;
        if ((cm | mm | zm) != 0) begin
          if (err < CMAX) err++;
          if (st == 1) begin
            st = 2; fexp = m; fgot = int'(count_out); ftyp = cm | (mm << 1) | (zm << 2);
          end
        end
      end
      if (!rst_n)       m = 0;
      else if (!load_n) m = int'(data_load);
      else if (ce)      m = up_down ? (m + 1) % (VMAX + 1) : (m + VMAX) % (VMAX + 1);
    end
    #1;
    check("synced", synced, st != 0);
    check("err_flag", err_flag, st == 2);
    check("chk_count", chk_count, chk);
    check("err_count", err_count, err);
    check("first_exp", first_exp, fexp);
    check("first_got", first_got, fgot);
    check("first_type", first_type, ftyp);
  endtask

  initial begin
    // Reset state
    rst = 1; ctl(1, 1, 1, 0, 0); step();
    rst = 0;
    // Unsynced: model tracks, nothing compared (even with a faulty counter)
    for (int i = 0; i < 6; i++) begin
      ctl(1, $urandom_range(3) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(VMAX));
      step($urandom_range(1), 0, 0);
    end
    check("unsync_chk", chk_count, 0);
    // Sync, then 5 up counts
    ctl(0, 1, 1, 0, 0); step();
    for (int i = 0; i < 5; i++) begin ctl(1, 1, 1, 1, 0); step(); end
    check("sync_chk5", chk_count, 5);
    check("sync_flag", synced, 1);
    // Up wrap 14 -> 15 -> 0 -> 1
    ctl(1, 0, 1, 0, 14); step();
    for (int i = 0; i < 3; i++) begin ctl(1, 1, 1, 1, 0); step(); end
    // Down wrap 1 -> 0 -> 15
    ctl(1, 0, 0, 0, 1); step();
    for (int i = 0; i < 2; i++) begin ctl(1, 1, 0, 1, 0); step(); end
    check("wrap_noerr", err_count, 0);
    check("wrap_m15", m, 15);
    // Priority: load beats ce, rst_n beats load
    ctl(1, 0, 1, 1, 9); step();
    check("prio_load", m, 9);
    ctl(0, 0, 1, 1, 5); step();
    check("prio_rstn", m, 0);
    ctl(1, 1, 1, 0, 0); step();
    // Injected fault: expect 7, show 8
    ctl(1, 0, 1, 0, 7); step();
    ctl(1, 1, 1, 0, 0); step(1, 0, 0);
    check("fault_flag", err_flag, 1);
    check("fault_exp", first_exp, 7);
    check("fault_got", first_got, 8);
    check("fault_type", first_type, 3'b001);
    check("fault_err1", err_count, 1);
    step(0, 1, 1);
    check("fault_err2", err_count, 2);
    check("fault_hold", first_type, 3'b001);
    // rst_n while failed: model only
    ctl(0, 1, 1, 1, 0); step();
    ctl(1, 1, 1, 1, 0); step();
    check("rstn_keep", err_flag, 1);
    // clr with mismatch in FAIL
    clr = 1; step(1, 0, 0); clr = 0;
    check("clr_sync", synced, 0);
    check("clr_err", err_count, 0);
    // Resync and saturate chk_count
    ctl(0, 1, 1, 0, 0); step();
    for (int i = 0; i < 20; i++) begin ctl(1, 1, $urandom_range(1), 1, 0); step(); end
    check("sat_chk", chk_count, 15);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(99) == 0);
      clr = ($urandom_range(29) == 0);
      ctl($urandom_range(7) != 0, $urandom_range(5) != 0, $urandom_range(1),
          $urandom_range(3) != 0, $urandom_range(VMAX));
      step($urandom_range(9) == 0, $urandom_range(19) == 0, $urandom_range(19) == 0);
    end
    rst = 0; clr = 0;
    // Force a FAIL then rst mid-FAIL
    ctl(0, 1, 1, 0, 0); step();
    ctl(1, 1, 1, 1, 0); step(1, 0, 0);
    check("pre_rst_fail", err_flag, 1);
    rst = 1; step(); rst = 0;
    check("rst_fail_clr", err_flag, 0);
    check("rst_fail_type", first_type, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
